// File: rtl/transfer_ctrl_hub.sv
// Serial command/data receiver: deserialises a bit stream into words, decodes scanner commands and
// queues length-prefixed binary/ASCII payloads into a FIFO for a valid/ready consumer.
module transfer_ctrl_hub #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned N_SCAN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ser_valid,
  input  logic              i_ser_data,
  input  logic              i_rdy_in,
  output logic              o_rdy_out,
  output logic [N_SCAN-1:0] o_scan_start,
  output logic [N_SCAN-1:0] o_scan_flush,
  output logic [WORD_W-1:0] o_out_data,
  output logic              o_out_ascii,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_cmd_err,
  output logic              o_overflow
);

  localparam int unsigned CH_W = WORD_W - 4;
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned BW   = $clog2(WORD_W);

  localparam logic [3:0] OP_BUF50 = 4'd1;
  localparam logic [3:0] OP_BUF80 = 4'd2;
  localparam logic [3:0] OP_BUF90 = 4'd3;
  localparam logic [3:0] OP_FULL  = 4'd4;
  localparam logic [3:0] OP_FLUSH = 4'd5;
  localparam logic [3:0] OP_READY = 4'd6;
  localparam logic [3:0] OP_BIN   = 4'd7;
  localparam logic [3:0] OP_ASCII = 4'd8;

  typedef enum logic [1:0] {StCmd, StLen, StData} state_e;

  // Deserialiser
  logic [WORD_W-2:0] r_shift;
  logic [BW-1:0]     r_bit_cnt;
  logic [WORD_W-1:0] r_word;
  logic              r_word_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_word     <= '0;
      r_word_vld <= 1'b0;
    end else begin
      r_word_vld <= 1'b0;
      if (i_ser_valid) begin
        r_shift <= {r_shift[WORD_W-3:0], i_ser_data};
        if (r_bit_cnt == BW'(WORD_W - 1)) begin
          r_bit_cnt  <= '0;
          r_word     <= {r_shift, i_ser_data};
          r_word_vld <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + BW'(1);
        end
      end
    end
  end

  // Command decode
  logic [3:0]      w_op;
  logic [CH_W-1:0] w_ch;
  logic            w_ch_ok;

  assign w_op    = r_word[3:0];
  assign w_ch    = r_word[WORD_W-1:4];
  assign w_ch_ok = {1'b0, w_ch} < (CH_W + 1)'(N_SCAN);

  state_e            r_state;
  logic              r_follow;
  logic              r_ascii;
  logic [WORD_W-1:0] r_len;
  logic [N_SCAN-1:0] r_scan_start;
  logic [N_SCAN-1:0] r_scan_flush;
  logic              r_cmd_err;
  logic              r_rdy_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StCmd;
      r_follow     <= 1'b0;
      r_ascii      <= 1'b0;
      r_len        <= '0;
      r_scan_start <= '0;
      r_scan_flush <= '0;
      r_cmd_err    <= 1'b0;
      r_rdy_out    <= 1'b0;
    end else begin
      r_scan_start <= '0;
      r_scan_flush <= '0;
      r_cmd_err    <= 1'b0;
      r_rdy_out    <= r_follow & i_rdy_in;
      if (r_word_vld) begin
        unique case (r_state)
          StCmd: begin
            case (w_op)
              OP_BUF50: begin
                r_follow <= 1'b0;
                if (!w_ch_ok) r_cmd_err <= 1'b1;
                for (int unsigned i = 0; i < N_SCAN; i++) begin
                  if (w_ch_ok && w_ch == CH_W'(i)) r_scan_flush[i] <= 1'b1;
                end
              end
              OP_BUF90: begin
                r_follow <= 1'b1;
                if (!w_ch_ok) r_cmd_err <= 1'b1;
                for (int unsigned i = 0; i < N_SCAN; i++) begin
                  if (w_ch_ok && w_ch == CH_W'(i)) r_scan_start[i] <= 1'b1;
                end
              end
              OP_BUF80, OP_FULL, OP_READY: r_follow <= 1'b1;
              OP_FLUSH: ;  // FIFO clear is handled alongside the pointers
              OP_BIN, OP_ASCII: begin
                r_follow <= 1'b1;
                r_ascii  <= (w_op == OP_ASCII);
                r_state  <= StLen;
              end
              default: r_cmd_err <= 1'b1;
            endcase
          end
          StLen: begin
            if (r_word == '0) begin
              r_state <= StCmd;
            end else begin
              r_len   <= r_word;
              r_state <= StData;
            end
          end
          StData: begin
            r_len <= r_len - WORD_W'(1);
            if (r_len == WORD_W'(1)) r_state <= StCmd;
          end
          default: r_state <= StCmd;
        endcase
      end
    end
  end

  // Payload FIFO
  logic [WORD_W:0] r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            r_overflow;
  logic            w_push;
  logic            w_pop;
  logic            w_wr;
  logic            w_flush;
  logic [WORD_W:0] w_head;

  assign w_push  = r_word_vld && (r_state == StData);
  assign w_flush = r_word_vld && (r_state == StCmd) && (w_op == OP_FLUSH);
  assign w_pop   = o_out_valid & i_out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_wr    = w_push && ((r_count != (AW + 1)'(DEPTH)) || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_push && !w_wr) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= {r_ascii, r_word};
  end

  assign w_head       = r_mem[r_rd_ptr];
  assign o_out_valid  = (r_count != '0);
  assign o_out_data   = o_out_valid ? w_head[WORD_W-1:0] : '0;
  assign o_out_ascii  = o_out_valid & w_head[WORD_W];
  assign o_overflow   = r_overflow;
  assign o_rdy_out    = r_rdy_out;
  assign o_scan_start = r_scan_start;
  assign o_scan_flush = r_scan_flush;
  assign o_cmd_err    = r_cmd_err;

endmodule

// File: tb/tb_transfer_ctrl_hub.sv
// Scoreboard bench for transfer_ctrl_hub: directed command/payload vectors, expected pulses and
// FIFO words queued at stimulus time and matched by a negedge monitor.
module tb_transfer_ctrl_hub;

  logic       clk = 1'b0;
  logic       rst;
  logic       ser_valid;
  logic       ser_data;
  logic       rdy_in;
  logic       rdy_out;
  logic [1:0] scan_start;
  logic [1:0] scan_flush;
  logic [7:0] out_data;
  logic       out_ascii;
  logic       out_valid;
  logic       out_ready;
  logic       cmd_err;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  // Pulse events {start[1:0], flush[1:0], err}; FIFO words {ascii, data}
  logic [4:0] ev_q[$];
  logic [8:0] dat_q[$];

  transfer_ctrl_hub #(
    .WORD_W(8),
    .DEPTH (16),
    .N_SCAN(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_ser_valid (ser_valid),
    .i_ser_data  (ser_data),
    .i_rdy_in    (rdy_in),
    .o_rdy_out   (rdy_out),
    .o_scan_start(scan_start),
    .o_scan_flush(scan_flush),
    .o_out_data  (out_data),
    .o_out_ascii (out_ascii),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_cmd_err   (cmd_err),
    .o_overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Monitor
  always @(negedge clk) begin
    logic [4:0] ev_got;
    logic [4:0] ev_exp;
    logic [8:0] d_exp;
    if (!rst) begin
      ev_got = {scan_start, scan_flush, cmd_err};
      if (ev_got != 5'b0) begin
        n_checks++;
        if (ev_q.size() == 0) begin
          n_fail++;
          $display("FAIL pulse_unexpected: got %b, none expected", ev_got);
        end else begin
          ev_exp = ev_q.pop_front();
          if (ev_got !== ev_exp) begin
            n_fail++;
            $display("FAIL pulse: got %b, expected %b", ev_got, ev_exp);
          end
        end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (dat_q.size() == 0) begin
          n_fail++;
          $display("FAIL fifo_unexpected: got %h, none expected", {out_ascii, out_data});
        end else begin
          d_exp = dat_q.pop_front();
          if ({out_ascii, out_data} !== d_exp) begin
            n_fail++;
            $display("FAIL fifo_word: got %h, expected %h", {out_ascii, out_data}, d_exp);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bits(input logic [7:0] w, input int nbits, input int gap);
    for (int b = 7; b > 7 - nbits; b--) begin
      ser_valid = 1'b1;
      ser_data  = w[b];
      tick(1);
      ser_valid = 1'b0;
      if (b != 8 - nbits) tick(gap);
    end
  endtask

  task automatic send_word(input logic [7:0] w, input int gap);
    send_bits(w, 8, gap);
  endtask

  task automatic check_reset_state();
    check("rst_rdy_out", rdy_out, 0);
    check("rst_scan_start", scan_start, 0);
    check("rst_scan_flush", scan_flush, 0);
    check("rst_cmd_err", cmd_err, 0);
    check("rst_overflow", overflow, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", {out_ascii, out_data}, 0);
  endtask

  initial begin
    logic prev;
    logic [5:0] pattern;
    rst = 1'b1; ser_valid = 1'b0; ser_data = 1'b0; rdy_in = 1'b0; out_ready = 1'b0;
    tick(3);
    rst = 1'b0;
    check_reset_state();

    // 1: BUF90 ch0
    rdy_in = 1'b1;
    ev_q.push_back(5'b01_00_0);
    send_word(8'h03, 0);
    tick(1);
    check("t1_rdy_out_lag", rdy_out, 0);
    tick(1);
    check("t1_rdy_out", rdy_out, 1);

    // 2: BUF90 ch1, BUF50 ch2 (bad channel), BUF50 ch1
    ev_q.push_back(5'b10_00_0);
    send_word(8'h13, 0);
    ev_q.push_back(5'b00_00_1);
    send_word(8'h21, 0);
    tick(3);
    check("t2_rdy_out_cleared", rdy_out, 0);
    ev_q.push_back(5'b00_10_0);
    send_word(8'h11, 1);
    ev_q.push_back(5'b00_00_1);
    send_word(8'h09, 0);  // unknown opcode

    // 3: binary payload of 3 with gaps
    send_word(8'h07, 2);
    send_word(8'h03, 1);
    dat_q.push_back({1'b0, 8'hA5});
    dat_q.push_back({1'b0, 8'h5A});
    dat_q.push_back({1'b0, 8'hFF});
    send_word(8'hA5, 3);
    send_word(8'h5A, 1);
    send_word(8'hFF, 2);
    tick(2);
    check("t3_out_valid", out_valid, 1);
    check("t3_head", {out_ascii, out_data}, {1'b0, 8'hA5});
    out_ready = 1'b1;
    tick(4);
    out_ready = 1'b0;
    check("t3_drained", out_valid, 0);

    // 4: ASCII payload of 20 into a 16-deep FIFO
    send_word(8'h08, 0);
    send_word(8'h14, 0);
    for (int i = 0; i < 20; i++) begin
      if (i < 16) dat_q.push_back({1'b1, 8'(8'h40 + i)});
      send_word(8'(8'h40 + i), 0);
      if (i == 15) begin
        tick(2);
        check("t4_no_overflow_at_16", overflow, 0);
      end
      if (i == 16) begin
        tick(2);
        check("t4_overflow_at_17", overflow, 1);
      end
    end
    ev_q.push_back(5'b01_00_0);
    send_word(8'h03, 0);  // must decode as command after the 20th word
    tick(2);
    check("t4_full_head", {out_ascii, out_data}, {1'b1, 8'h40});
    out_ready = 1'b1;
    tick(17);
    out_ready = 1'b0;
    check("t4_drained", out_valid, 0);

    // FLUSH clears queued payload, keeps overflow
    send_word(8'h07, 0);
    send_word(8'h02, 0);
    send_word(8'h10, 0);
    send_word(8'h20, 0);
    tick(1);
    check("flush_pre_valid", out_valid, 1);
    send_word(8'h05, 0);
    tick(1);
    check("flush_valid", out_valid, 0);
    check("flush_overflow_kept", overflow, 1);

    // 5: BUF50 holds rdy_out low, READY makes it follow rdy_in
    rdy_in = 1'b1;
    ev_q.push_back(5'b00_01_0);
    send_word(8'h01, 0);
    tick(2);
    check("t5_rdy_out_low_a", rdy_out, 0);
    tick(3);
    check("t5_rdy_out_low_b", rdy_out, 0);
    send_word(8'h06, 0);
    tick(3);
    prev = 1'b1;
    pattern = 6'b101101;
    for (int i = 0; i < 6; i++) begin
      rdy_in = pattern[i];
      #1;
      check("t5_rdy_out_before_edge", rdy_out, prev);
      tick(1);
      check("t5_rdy_out_after_edge", rdy_out, pattern[i]);
      prev = pattern[i];
    end

    // 6: reset mid-payload / mid-word
    send_word(8'h07, 0);
    send_word(8'h02, 0);
    send_word(8'h33, 0);
    tick(1);
    check("t6_pre_valid", out_valid, 1);
    send_bits(8'hA0, 4, 0);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    check_reset_state();
    rdy_in = 1'b1;
    ev_q.push_back(5'b01_00_0);
    send_word(8'h03, 0);
    tick(3);
    check("t6_rdy_out", rdy_out, 1);
    check("t6_out_valid", out_valid, 0);

    tick(5);
    check("pending_pulses", ev_q.size(), 0);
    check("pending_fifo_words", dat_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
